rng_word_packer: RTL
====================

Name: rng_word_packer

Overview:
- Downstream consumer of the hysteresis RNG core. Runs on the same slow clock as that core.
- Takes its per-cycle sample (bit_valid/bit_in, driven by the core's done/rnd_bit) and removes bias with a von Neumann corrector.
- Packs the corrected bits into WIDTH-bit words and presents them on a valid/ready output with a one-word holding register.
- Counts words dropped under backpressure.

Parameters:
- WIDTH, 32, output word width; legal range 2..64.
- RCT_CUTOFF, 16, repetition-count cutoff on raw bits; used only with the optional feature; legal range 2..255.

Ports:
- clk  input  1  single clock; the RNG core's sampling clock.
- rst_b  input  1  asynchronous active-low reset.
- bit_valid  input  1  raw sample strobe; connected to the core's done.
- bit_in  input  1  raw sample; connected to the core's rnd_bit.
- word_ready  input  1  downstream accepts word this cycle.
- word_valid  output  1  word holds an unconsumed random word.
- word  output  WIDTH  packed random word; newest bit in the LSB.
- drop_cnt  output  8  saturating count of words lost to backpressure.
- hlth_fail  output  1  sticky health-test failure; constant 0 without the feature.

Behaviour:
- Reset, asynchronous, rst_b=0:
  - word_valid=0, word=0, drop_cnt=0, hlth_fail=0.
  - Corrector state=IDLE, accumulator=0, bit count=0.
  - Reset asserted mid-pair or mid-word discards all partial state.
- Sampling: bit_in is used only on clk rising edges where bit_valid=1. Other cycles leave all corrector and accumulator state unchanged, so gaps of any length between samples are allowed.
- Corrector FSM:
  - IDLE + bit_valid: store a=bit_in, go to HALF.
  - HALF + bit_valid with b=bit_in:
    - If a!=b, emit corrected bit a: pair 1,0 -> 1; pair 0,1 -> 0.
    - If a==b, emit nothing.
    - Always return to IDLE.
- Accumulator:
  - Each emitted bit gives acc <= {acc[WIDTH-2:0], bit} and cnt <= cnt+1.
  - cnt counts 0..WIDTH-1.
  - The emit that completes WIDTH bits is a "word complete" event. It sets cnt to 0 and acc to 0 in the same edge.
- Load on word complete, in priority order:
  - Output register empty (word_valid=0) or draining this cycle (word_valid & word_ready): word <= completed word and word_valid=1 from the next cycle.
  - Otherwise the completed word is dropped. drop_cnt increments by 1 and saturates at 255, never wrapping. word is unchanged.
- Output handshake:
  - A transfer happens on a clk edge with word_valid=1 & word_ready=1.
  - While word_valid=1 and word_ready=0, word and word_valid hold stable.
  - Transfer without a load: word_valid goes to 0 next cycle; word keeps its old value.
  - Transfer and load in the same cycle: word_valid stays 1 and word takes the new value.
  - word_ready is ignored while word_valid=0.
- Latency: a word is visible one cycle after the clk edge that samples the second bit of the completing pair.
- Throughput: at most one word per 2*WIDTH bit_valid strobes.

Optional Feature:
- Macro: RNG_PACK_RCT_EN.
- Defined: repetition-count test on raw bit_in, counted on bit_valid cycles only.
  - An 8-bit run counter starts at 1 on the first sample after reset, increments when bit_in equals the previous raw bit, and restarts at 1 otherwise.
  - When the run reaches RCT_CUTOFF, hlth_fail is set on that edge and stays 1 until reset.
  - While hlth_fail=1, word-complete events neither load nor increment drop_cnt. A word already in the register may still drain.
  - The corrector and accumulator keep running.
- Undefined: no run counter logic; hlth_fail is tied to 0.

Test Plan:
- Reset: apply rst_b=0 mid-operation with HALF state and cnt=5 -> all outputs 0 asynchronously. After release, the first pair starts from IDLE.
- Packing, WIDTH=8, word_ready=1: pairs producing bits 1,0,1,1,0,0,1,0 -> word=8'hB2 with word_valid high for exactly one cycle, one cycle after the 16th bit_valid.
- Discard, WIDTH=8: 16 pairs of 1,1 plus 16 pairs of 0,0 -> word_valid stays 0 and cnt stays 0. Then 8 pairs of 0,1 -> word=8'h00 valid.
- Backpressure, WIDTH=8, word_ready=0: complete three words -> the first word is held stable and drop_cnt=2. Raise word_ready for one cycle -> transfer and word_valid=0.
  - Continuing to 300 drops -> drop_cnt=255.
- Simultaneous events: word_valid=1, word_ready=1 in the same cycle a word completes -> word_valid stays 1 and word takes the new value.
  - Gaps: bit_valid gaps of 0..7 cycles between samples -> identical words.
- With RNG_PACK_RCT_EN and RCT_CUTOFF=16: 16 consecutive raw 1s -> hlth_fail=1 after the 16th sample.
  - Subsequent words are not loaded and drop_cnt is unchanged.
  - rst_b=0 clears hlth_fail.

Source files
------------

// File: rtl/rng_word_packer.sv
// Von Neumann debiaser and WIDTH-bit word packer for the hysteresis RNG core, with a one-word output holding register.
// Optional raw-bit repetition-count health test when RNG_PACK_RCT_EN is defined.
module rng_word_packer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RCT_CUTOFF = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             word_ready,
  output logic             word_valid,
  output logic [WIDTH-1:0] word,
  output logic [7:0]       drop_cnt,
  output logic             hlth_fail
);

  localparam int unsigned CNT_W    = $clog2(WIDTH);
  localparam int unsigned DROP_W   = 8;
  localparam int unsigned RUN_W    = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("rng_word_packer: WIDTH out of range 2..64");
  end
  if (RCT_CUTOFF < 2 || RCT_CUTOFF > 255) begin : g_bad_cutoff
    $error("rng_word_packer: RCT_CUTOFF out of range 2..255");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } pair_state_e;

  pair_state_e       state_q, state_d;
  logic              a_q, a_d;
  logic [WIDTH-2:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              emit;
  logic              complete;
  logic              load_block;
  logic [WIDTH-1:0]  acc_shift;

  // Corrector, accumulator and output holding register next-state.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    drop_cnt_d   = drop_cnt_q;
    emit         = 1'b0;
    complete     = 1'b0;
    acc_shift    = {acc_q, a_q};

    if (bit_valid) begin
      if (state_q == IDLE) begin
        a_d     = bit_in;
        state_d = HALF;
      end else begin
        state_d = IDLE;
        emit    = (bit_in != a_q);
      end
    end

    // The accumulator only ever holds WIDTH-1 bits; the completing bit goes straight to the output.
    if (emit) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        complete = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = acc_shift[WIDTH-2:0];
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    if (complete && !load_block) begin
      if (!word_valid_q || word_ready) begin
        word_d       = acc_shift;
        word_valid_d = 1'b1;
      end else if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      a_q          <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

`ifdef RNG_PACK_RCT_EN
  logic [RUN_W-1:0] run_q, run_d;
  logic             prev_q, prev_d;
  logic             hlth_fail_q, hlth_fail_d;

  // Run length of identical raw samples; run_q==0 means no sample seen since reset.
  always_comb begin
    run_d       = run_q;
    prev_d      = prev_q;
    hlth_fail_d = hlth_fail_q;
    if (bit_valid) begin
      prev_d = bit_in;
      if (run_q != '0 && bit_in == prev_q) begin
        run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);
      end else begin
        run_d = RUN_W'(1);
      end
      if (run_d == RUN_W'(RCT_CUTOFF)) begin
        hlth_fail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      run_q       <= '0;
      prev_q      <= 1'b0;
      hlth_fail_q <= 1'b0;
    end else begin
      run_q       <= run_d;
      prev_q      <= prev_d;
      hlth_fail_q <= hlth_fail_d;
    end
  end

  assign load_block = hlth_fail_q;
  assign hlth_fail  = hlth_fail_q;
`else
  assign load_block = 1'b0;
  assign hlth_fail  = 1'b0;
`endif

  assign word_valid = word_valid_q;
  assign word       = word_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
